tl_async_queue_source: RTL
==========================

# tl_async_queue_source

Parametrised write-side half of a clock-domain-crossing queue for TileLink-style channels. It accepts beats on a ready/valid port, stores them in a register-based ring, and publishes the ring contents and a Gray-coded write index to a sink in another clock domain. It synchronises the sink's Gray read index back into its own domain to derive full, level and drained status. This generation adds configurable width, depth and synchroniser length, plus occupancy reporting, which the fixed-depth source lacks.

## Interface
- WIDTH, 32, payload bits per beat (≥1)
- DEPTH, 8, ring entries; power of two, ≥2; AW = log2(DEPTH)
- SYNC, 3, flop stages on the incoming read index (≥2)
- clock  in  1  sole clock; all state is posedge-triggered.
- reset  in  1  asynchronous, active-high; asserting it immediately forces every register to its reset value.
- enq_valid  in  1  producer has a beat
- enq_ready  out  1  ring not full
- enq_bits  in  WIDTH  beat payload
- async_mem  out  DEPTH*WIDTH  ring storage; entry i occupies bits [i*WIDTH +: WIDTH]
- async_widx  out  AW+1  Gray-coded write index, driven directly from a register
- async_ridx  in  AW+1  Gray-coded read index from the sink; treated as asynchronous
- level  out  AW+1  entries written but not yet acknowledged, range 0..DEPTH
- drained  out  1  level == 0

## Operation
- wbin: AW+1-bit binary write counter. widx_q: AW+1-bit Gray register. mem: DEPTH×WIDTH registers. rsync: SYNC-deep register chain of AW+1 bits each.
- Reset values are all zero: wbin, widx_q, every mem entry and every rsync stage. After reset, enq_ready=1, level=0, drained=1 and async_widx=0.
- rsync[0] samples async_ridx. Each later stage shifts from the previous one. ridx_s = rsync[SYNC-1]. No logic may sit between async_ridx and rsync[0].
- full = (widx_q == ridx_s ^ {2'b11, (AW-1)'b0}), i.e. the top two bits are inverted and the rest are equal.
- enq_ready = !full. It is a function of registers only, never of enq_valid.
- fire = enq_valid & enq_ready. On fire:
  - mem[wbin[AW-1:0]] ← enq_bits
  - wbin ← wbin+1, mod 2^(AW+1)
  - widx_q ← (wbin+1) ^ ((wbin+1)>>1)
- Without fire, wbin, widx_q and mem hold.
- async_widx changes by exactly one bit per fire. A mem entry is never written while the sink may read it, because full blocks the write.
- level = (wbin − gray2bin(ridx_s)) mod 2^(AW+1). Any value > DEPTH indicates a protocol violation; the bench flags it, and the RTL need not handle it.
- enq_valid with enq_ready=0 is legal. The beat is held upstream and no state changes.
- Wrap-around: wbin rolls from 2^(AW+1)−1 to 0 with no special handling. Full/empty detection stays correct across the wrap.

## Timing
- Write latency: for a fire at edge k, mem and async_widx show the new values after edge k. The sink observes them after its own synchroniser.
- Read-index return: a change on async_ridx before edge k appears in ridx_s after edge k+SYNC−1. enq_ready and level update in that same cycle.
- Throughput is one beat per cycle while not full.
- Simultaneous fire and ridx_s advance in the same cycle: both take effect, and level is unchanged net.
- Full to not-full: enq_ready rises in the cycle ridx_s advances. No extra bubble is allowed.
- Reset mid-operation: all state clears immediately and asynchronously. In-flight beats are discarded. The sink is reset by its own domain; coordinating the two resets is a system-level requirement.

## Test plan
- Reset, defaults (WIDTH=32, DEPTH=8, SYNC=3): enq_ready=1, drained=1, level=0, async_widx=0, async_mem=0.
- Fill: async_ridx held at 0, then 8 back-to-back fires with enq_bits=0xA0..0xA7 → mem[0..7]=0xA0..0xA7, async_widx=0b1100, level=8, enq_ready=0 after the 8th fire. A 9th enq_valid is ignored.
- Drain return: from full, drive async_ridx=0b0001 at cycle t → enq_ready=1 and level=7 at t+2 (SYNC=3), not earlier.
- Wrap: 35 fires interleaved with matching ridx returns → async_widx steps through the Gray sequence with exactly one bit change per fire, wbin wraps 15→0, and no false full or false drained occurs.
- Simultaneous: level=4, fire in the same cycle ridx_s advances by one → level stays 4 and the data lands at the correct index.
- Reset mid-fill: assert reset between edges with level=5 → all outputs return to reset values before the next edge. A subsequent fire writes mem[0].

Source files
------------

// File: rtl/tl_async_queue_source.sv
// Write side of a clock-domain-crossing queue for TileLink-style channels.
// Beats land in a register ring published to the sink along with a Gray write index.
module tl_async_queue_source #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int SYNC  = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [WIDTH-1:0]       enq_bits,
    output logic [DEPTH*WIDTH-1:0] async_mem,
    output logic [AW:0]            async_widx,
    input  logic [AW:0]            async_ridx,
    output logic [AW:0]            level,
    output logic                   drained
);

    // Gray indices differ in their top two bits exactly when the ring is full.
    localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW-1);

    logic [AW:0]      wbin_q;
    logic [AW:0]      wbin_d;
    logic [AW:0]      widx_q;
    logic [AW:0]      widx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      rsync_q [SYNC];
    logic [AW:0]      ridxS;
    logic             full;
    logic             fire;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign ridxS     = rsync_q[SYNC-1];
    assign full      = (widx_q == (ridxS ^ FULL_MASK));
    assign enq_ready = !full;
    assign fire      = enq_valid && enq_ready;

    always_comb begin
        wbin_d = wbin_q;
        widx_d = widx_q;
        if (fire) begin
            wbin_d = wbin_q + (AW+1)'(1);
            widx_d = wbin_d ^ (wbin_d >> 1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbin_q <= '0;
            widx_q <= '0;
        end else begin
            wbin_q <= wbin_d;
            widx_q <= widx_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fire) begin
            mem_q[wbin_q[AW-1:0]] <= enq_bits;
        end
    end

    // The first stage samples the foreign index with no logic in front of it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC; i++) begin
                rsync_q[i] <= '0;
            end
        end else begin
            rsync_q[0] <= async_ridx;
            for (int i = 1; i < SYNC; i++) begin
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gMem
        assign async_mem[g*WIDTH +: WIDTH] = mem_q[g];
    end

    assign async_widx = widx_q;
    assign level      = wbin_q - gray2bin(ridxS);
    assign drained    = (level == '0);

endmodule
